// File: rtl/datapath_sequencer_if.sv
// ---------------------------------------------------------------------------
// datapath_sequencer_if
// Command handshake and datapath control bus for datapath_sequencer.
//
// Signals:
//   start              command request, sampled when ready=1
//   opcode[1:0]        00 LDI, 01 ADDI, 10 MVB, 11 ADDB
//   imm[31:0]          command immediate
//   ready              a command is accepted on this edge if start=1
//   busy               sequencer is not idle
//   done               one-cycle pulse at command completion
//   RAout/RBout/RZout  register drive enables onto the datapath bus
//   RAin/RBin/RZin     register load enables from the datapath bus
//   AddImmediate       adder operand (ALU cycle only, zero otherwise)
//   RegisterAImmediate RA load value (LD cycle only, zero otherwise)
//
// Modports:
//   master  issues commands and observes the control outputs
//   slave   the sequencer itself
// ---------------------------------------------------------------------------
interface datapath_sequencer_if;
    logic        start;
    logic [1:0]  opcode;
    logic [31:0] imm;
    logic        ready;
    logic        busy;
    logic        done;
    logic        RAout;
    logic        RBout;
    logic        RZout;
    logic        RAin;
    logic        RBin;
    logic        RZin;
    logic [31:0] AddImmediate;
    logic [31:0] RegisterAImmediate;

    modport master (
        output start, opcode, imm,
        input  ready, busy, done,
        input  RAout, RBout, RZout, RAin, RBin, RZin,
        input  AddImmediate, RegisterAImmediate
    );

    modport slave (
        input  start, opcode, imm,
        output ready, busy, done,
        output RAout, RBout, RZout, RAin, RBin, RZin,
        output AddImmediate, RegisterAImmediate
    );
endinterface

// File: rtl/datapath_sequencer.sv
// ---------------------------------------------------------------------------
// datapath_sequencer
// Control sequencer for a small register datapath (RA, RB, adder output Z).
// Each accepted command is latched and then stepped through a fixed sequence
// of Moore states that raise the datapath bus enables:
//   LDI  : LD  -> DONE            (RA <= imm)
//   ADDI : ALU -> WB -> DONE      (RA <= RA + imm)
//   MVB  : MV  -> DONE            (RB <= Z)
//   ADDB : ALU -> WB -> DONE      (RB <= RB + imm)
// The addition itself happens in the datapath; imm is passed through as-is.
//
// Ports:
//   clock  system clock, all state changes on the rising edge
//   clear  synchronous active-high reset
//   bus    datapath_sequencer_if.slave (handshake, enables, immediates)
//
// Configuration:
//   DATAPATH_SEQ_QUEUE_EN  when defined, adds a one-entry pending command
//                          slot so a command can be queued while busy and
//                          started straight out of DONE.
// ---------------------------------------------------------------------------
module datapath_sequencer (
    input  logic                 clock,
    input  logic                 clear,
    datapath_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        LD,
        ALU,
        WB,
        MV,
        DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    // Command currently being executed, latched when it launches
    logic [1:0]  cmd_op;
    logic [31:0] cmd_imm;

    logic        ready;
    logic        accept;
    logic        launch;
    logic [1:0]  launch_op;
    logic [31:0] launch_imm;

`ifdef DATAPATH_SEQ_QUEUE_EN
    logic        pend_valid;
    logic        pend_valid_next;
    logic [1:0]  pend_op;
    logic [1:0]  pend_op_next;
    logic [31:0] pend_imm;
    logic [31:0] pend_imm_next;
`endif

    // First execution state of a command, chosen purely by opcode
    function automatic state_t first_state(input logic [1:0] op);
        case (op)
            2'b00:   return LD;
            2'b10:   return MV;
            default: return ALU;
        endcase
    endfunction

    // With the pending slot, a command may be offered whenever the slot is
    // free; without it, only an idle sequencer takes commands.
`ifdef DATAPATH_SEQ_QUEUE_EN
    assign ready = (state == IDLE) || !pend_valid;
`else
    assign ready = (state == IDLE);
`endif
    assign accept = bus.start && ready;

    // State register, latched command and (optionally) the pending slot.
    // clear wins over everything, including a start in the same cycle.
    always_ff @(posedge clock) begin
        if (clear) begin
            state   <= IDLE;
            cmd_op  <= 2'b00;
            cmd_imm <= 32'h0;
`ifdef DATAPATH_SEQ_QUEUE_EN
            pend_valid <= 1'b0;
            pend_op    <= 2'b00;
            pend_imm   <= 32'h0;
`endif
        end else begin
            state <= state_next;
            if (launch) begin
                cmd_op  <= launch_op;
                cmd_imm <= launch_imm;
            end
`ifdef DATAPATH_SEQ_QUEUE_EN
            pend_valid <= pend_valid_next;
            pend_op    <= pend_op_next;
            pend_imm   <= pend_imm_next;
`endif
        end
    end

    // Next-state logic. A "launch" loads a command into the execution
    // registers and jumps to its first state; it comes either straight from
    // the bus or, with the queue enabled, from the pending slot.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        launch_op  = bus.opcode;
        launch_imm = bus.imm;
`ifdef DATAPATH_SEQ_QUEUE_EN
        pend_valid_next = pend_valid;
        pend_op_next    = pend_op;
        pend_imm_next   = pend_imm;
`endif

        case (state)
            IDLE: begin
`ifdef DATAPATH_SEQ_QUEUE_EN
                // A command parked during the previous DONE goes first; a
                // start in this cycle then takes over the freed slot.
                if (pend_valid) begin
                    launch          = 1'b1;
                    launch_op       = pend_op;
                    launch_imm      = pend_imm;
                    pend_valid_next = accept;
                    if (accept) begin
                        pend_op_next  = bus.opcode;
                        pend_imm_next = bus.imm;
                    end
                end else if (accept) begin
                    launch = 1'b1;
                end
`else
                if (accept) begin
                    launch = 1'b1;
                end
`endif
            end
            LD:   state_next = DONE;
            ALU:  state_next = WB;
            WB:   state_next = DONE;
            MV:   state_next = DONE;
            DONE: begin
`ifdef DATAPATH_SEQ_QUEUE_EN
                // Back-to-back: skip IDLE and empty the slot on this edge
                if (pend_valid) begin
                    launch          = 1'b1;
                    launch_op       = pend_op;
                    launch_imm      = pend_imm;
                    pend_valid_next = 1'b0;
                end else begin
                    state_next = IDLE;
                end
`else
                state_next = IDLE;
`endif
            end
            default: state_next = IDLE;
        endcase

`ifdef DATAPATH_SEQ_QUEUE_EN
        // Any start accepted outside IDLE is parked in the slot
        if ((state != IDLE) && accept) begin
            pend_valid_next = 1'b1;
            pend_op_next    = bus.opcode;
            pend_imm_next   = bus.imm;
        end
`endif

        if (launch) begin
            state_next = first_state(launch_op);
        end
    end

    // Moore output decode from state and the latched command only, so no
    // combinational path exists from start/opcode/imm to the enables.
    always_comb begin
        bus.ready              = ready;
        bus.busy               = (state != IDLE);
        bus.done               = 1'b0;
        bus.RAout              = 1'b0;
        bus.RBout              = 1'b0;
        bus.RZout              = 1'b0;
        bus.RAin               = 1'b0;
        bus.RBin               = 1'b0;
        bus.RZin               = 1'b0;
        bus.AddImmediate       = 32'h0;
        bus.RegisterAImmediate = 32'h0;

        case (state)
            LD: begin
                bus.RegisterAImmediate = cmd_imm;
                bus.RAin               = 1'b1;
            end
            ALU: begin
                bus.AddImmediate = cmd_imm;
                bus.RZin         = 1'b1;
                bus.RAout        = (cmd_op == 2'b01);
                bus.RBout        = (cmd_op == 2'b11);
            end
            WB: begin
                bus.RZout = 1'b1;
                bus.RAin  = (cmd_op == 2'b01);
                bus.RBin  = (cmd_op == 2'b11);
            end
            MV: begin
                bus.RZout = 1'b1;
                bus.RBin  = 1'b1;
            end
            DONE: begin
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 The block SHALL provide: clock  input  1  single system clock, all state updates on rising edge.
REQ-002 The block SHALL provide: clear  input  1  synchronous, active-high reset, sampled on rising clock edge.
REQ-003 The block SHALL provide: start  input  1  command request, sampled when ready=1.
REQ-004 The block SHALL provide: opcode  input  2  00 LDI (RA<=imm), 01 ADDI (RA<=RA+imm), 10 MVB (RB<=Z), 11 ADDB (RB<=RB+imm).
REQ-005 The block SHALL provide: imm  input  32  command immediate.
REQ-006 The block SHALL provide: ready  output  1  a command is accepted on this edge if start=1.
REQ-007 The block SHALL provide: busy  output  1  FSM not in IDLE.
REQ-008 The block SHALL provide: done  output  1  one-cycle pulse at command completion.
REQ-009 The block SHALL provide: RAout, RBout, RZout, RAin, RBin, RZin  output  1 each  datapath bus enables, active-high.
REQ-010 The block SHALL provide: AddImmediate  output  32  adder operand; RegisterAImmediate  output  32  RA load value.

Function
REQ-011 The FSM SHALL use states IDLE, LD, ALU, WB, MV, DONE.
REQ-012 On an accepting edge, the block SHALL latch opcode and imm internally, and later input changes SHALL have no effect on that command.
REQ-013 Transitions SHALL be: IDLE->LD (00), IDLE->ALU (01, 11), IDLE->MV (10); LD->DONE; ALU->WB; WB->DONE; MV->DONE; DONE->IDLE (or next command per REQ-024).
REQ-014 Outputs SHALL be Moore-decoded from state and latched command only, with no combinational path from start or opcode.
REQ-015 In LD: RegisterAImmediate=imm and RAin=1.
REQ-016 In ALU: AddImmediate=imm and RZin=1, with RAout=1 for opcode 01 and RBout=1 for opcode 11.
REQ-017 In WB: RZout=1, with RAin=1 for opcode 01 and RBin=1 for opcode 11.
REQ-018 In MV: RZout=1 and RBin=1.
REQ-019 In every cycle, at most one of RAout, RBout, RZout SHALL be 1; both immediates SHALL be 32'h0 in every state other than the one driving them.
REQ-020 done SHALL be 1 only in DONE, and busy SHALL be 1 in all states except IDLE.
REQ-021 Latency from the accepting edge to done=1 SHALL be: LDI 2 cycles, MVB 2 cycles, ADDI/ADDB 3 cycles.
REQ-022 The addition is performed in the datapath; the block SHALL pass imm unmodified, with no width change or sign extension.

Reset
REQ-023 While clear=1 at a rising edge, the next state SHALL be IDLE, all enables and done SHALL be 0, immediates SHALL be 32'h0, latched command and pending slot SHALL be cleared, and ready=1; this holds mid-command, and start in the same cycle SHALL be ignored.

Configuration
REQ-024 Macro DATAPATH_SEQ_QUEUE_EN SHALL control a one-entry pending command buffer as follows:
- Defined: ready = IDLE or pending slot empty.
- A start while busy is stored in the pending slot.
- In DONE with the slot full, the next state is the first state of the pending command; the slot empties on that edge and done still pulses for one cycle.
- start in DONE with the slot empty fills the slot.
- Undefined: no slot exists, ready = (state==IDLE), and start while busy is ignored.

Verification
REQ-025 Reset, then LDI imm=5 -> one cycle later RAin=1 and RegisterAImmediate=32'h5, then done=1 for one cycle, then IDLE with all outputs 0.
REQ-026 ADDI imm=5 -> ALU cycle has RAout=1, RZin=1, AddImmediate=32'h5; WB cycle has RZout=1, RAin=1; done on the 3rd cycle after acceptance.
REQ-027 MVB then ADDB imm=32'hFFFFFFFF -> MV cycle has RZout=1, RBin=1; ADDB has RBout=1 and AddImmediate=32'hFFFFFFFF; at most one *out is high in every cycle.
REQ-028 clear asserted during the ADDI WB cycle -> next cycle is IDLE, all enables 0, done never pulses, and ready=1.
REQ-029 Macro undefined: start=1 (LDI imm=7) during an ADDI WB cycle -> ignored, so no LD state follows and a single done pulse occurs.
REQ-030 Macro defined: same stimulus -> LDI queued; DONE(ADDI) is followed directly by LD with imm=32'h7 and a second done pulse 2 cycles later, and ready=0 while the slot is full.
